// File: rtl/irq_controller.sv
// Two-vector interrupt controller: synchronise, edge-detect, latch pending, mask, fixed-priority issue.
// Optional timer interrupt input on vector 2 when IRQ_CTRL_TIMER_EN is defined.
module irq_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] irq_in,
  input  logic       we_mask,
  input  logic [1:0] mask_d,
  input  logic       iret,
`ifdef IRQ_CTRL_TIMER_EN
  input  logic       timer_tick,
`endif
  output logic       intr1,
  output logic       intr2,
  output logic [1:0] pending,
  output logic [1:0] mask,
  output logic       in_service
);

  // state   | meaning
  // IDLE    | no interrupt outstanding, arbitrating eligible requests
  // ISSUE   | request pulse on intr1/intr2 for this single cycle
  // SERVICE | CPU servicing the vector, waiting for iret
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] hist_q;
  logic [1:0] edge_evt;
  logic [1:0] set_vec;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] clr_vec;
  logic       issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 2'b00;
      end
      hist_q <= 2'b00;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_evt = sync_q[SYNC_STAGES-1] & ~hist_q;

`ifdef IRQ_CTRL_TIMER_EN
  assign set_vec = edge_evt | {timer_tick, 1'b0};
`else
  assign set_vec = edge_evt;
`endif

  assign eligible = pending & mask;

  always_comb begin
    grant = 2'b00;
    if (eligible[0]) begin
      grant = 2'b01;
    end else if (eligible[1]) begin
      grant = 2'b10;
    end
  end

  assign issue   = (state == IDLE) && (eligible != 2'b00);
  assign clr_vec = issue ? grant : 2'b00;

  // A new edge in the same cycle as the issue re-arms the bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 2'b00;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= 2'b00;
    end else if (we_mask) begin
      mask <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      intr1      <= 1'b0;
      intr2      <= 1'b0;
      in_service <= 1'b0;
    end else begin
      intr1 <= 1'b0;
      intr2 <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= ISSUE;
            intr1      <= grant[0];
            intr2      <= grant[1];
            in_service <= 1'b1;
          end
        end
        ISSUE: begin
          state <= SERVICE;
        end
        SERVICE: begin
          if (iret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: cycle table of inputs/expected outputs plus reset sequences.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] irq_in = 2'b00;
  logic       we_mask = 1'b0;
  logic [1:0] mask_d = 2'b00;
  logic       iret = 1'b0;
  logic       intr1, intr2, in_service;
  logic [1:0] pending, mask;
`ifdef IRQ_CTRL_TIMER_EN
  logic       timer_tick = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  irq_controller #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .we_mask(we_mask),
    .mask_d(mask_d),
    .iret(iret),
`ifdef IRQ_CTRL_TIMER_EN
    .timer_tick(timer_tick),
`endif
    .intr1(intr1),
    .intr2(intr2),
    .pending(pending),
    .mask(mask),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // exp packing: {intr1, intr2, pending[1:0], mask[1:0], in_service}
  typedef struct {
    logic [1:0] irq;
    logic       we;
    logic [1:0] md;
    logic       ir;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [49];

  function automatic vec_t mk(input logic [1:0] irq, input logic we, input logic [1:0] md,
                              input logic ir, input logic [6:0] e);
    vec_t v;
    v.irq = irq; v.we = we; v.md = md; v.ir = ir; v.exp = e;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {intr1, intr2, pending, mask, in_service};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    int n;
    // single request on line 0, five-cycle level
    tbl[0]  = mk(2'b00, 1'b1, 2'b11, 1'b0, 7'b0_0_00_11_0);
    tbl[1]  = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    tbl[2]  = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    tbl[3]  = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_01_11_0);
    tbl[4]  = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b1_0_00_11_1);
    tbl[5]  = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[6]  = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[7]  = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[8]  = mk(2'b00, 1'b0, 2'b00, 1'b1, 7'b0_0_00_11_0);
    tbl[9]  = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    // both lines together: vector 1 first, iret during ISSUE ignored
    tbl[10] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    tbl[11] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    tbl[12] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_11_11_0);
    tbl[13] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b1_0_10_11_1);
    tbl[14] = mk(2'b11, 1'b0, 2'b00, 1'b1, 7'b0_0_10_11_1);
    tbl[15] = mk(2'b11, 1'b0, 2'b00, 1'b1, 7'b0_0_10_11_0);
    tbl[16] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_1_00_11_1);
    tbl[17] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[18] = mk(2'b00, 1'b0, 2'b00, 1'b1, 7'b0_0_00_11_0);
    tbl[19] = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    tbl[20] = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_0);
    // masked line 1, then unmask
    tbl[21] = mk(2'b00, 1'b1, 2'b01, 1'b0, 7'b0_0_00_01_0);
    tbl[22] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_00_01_0);
    tbl[23] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_00_01_0);
    tbl[24] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_10_01_0);
    tbl[25] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_10_01_0);
    tbl[26] = mk(2'b10, 1'b1, 2'b11, 1'b0, 7'b0_0_10_11_0);
    tbl[27] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_1_00_11_1);
    tbl[28] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    // line 0 rises during SERVICE: latched, issued after iret
    tbl[29] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[30] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[31] = mk(2'b11, 1'b0, 2'b00, 1'b0, 7'b0_0_01_11_1);
    tbl[32] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_01_11_1);
    tbl[33] = mk(2'b10, 1'b0, 2'b00, 1'b1, 7'b0_0_01_11_0);
    tbl[34] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b1_0_00_11_1);
    tbl[35] = mk(2'b10, 1'b0, 2'b00, 1'b0, 7'b0_0_00_11_1);
    tbl[36] = mk(2'b10, 1'b0, 2'b00, 1'b1, 7'b0_0_00_11_0);
    // new edge on line 0 in the issue cycle: set beats clear
    tbl[37] = mk(2'b00, 1'b1, 2'b00, 1'b0, 7'b0_0_00_00_0);
    tbl[38] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_00_0);
    tbl[39] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_00_0);
    tbl[40] = mk(2'b00, 1'b0, 2'b00, 1'b0, 7'b0_0_01_00_0);
    tbl[41] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_01_00_0);
    tbl[42] = mk(2'b01, 1'b1, 2'b01, 1'b0, 7'b0_0_01_01_0);
    tbl[43] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b1_0_01_01_1);
    tbl[44] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_01_01_1);
    tbl[45] = mk(2'b01, 1'b0, 2'b00, 1'b1, 7'b0_0_01_01_0);
    tbl[46] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b1_0_00_01_1);
    tbl[47] = mk(2'b01, 1'b0, 2'b00, 1'b0, 7'b0_0_00_01_1);
    tbl[48] = mk(2'b00, 1'b0, 2'b00, 1'b1, 7'b0_0_00_01_0);

    // reset held with both lines high
    reset = 1'b0;
    irq_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", outs(), 7'b0);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("masked_no_pulse", {5'b0, intr1, intr2}, 7'b0);
    end
    chk("masked_pending", outs(), 7'b0_0_11_00_0);

    @(negedge clk);
    reset = 1'b0;
    irq_in = 2'b00;
    repeat (2) @(posedge clk);
    #1 chk("reset_clear", outs(), 7'b0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      irq_in  = tbl[i].irq;
      we_mask = tbl[i].we;
      mask_d  = tbl[i].md;
      iret    = tbl[i].ir;
      @(posedge clk); #1;
      chk($sformatf("row%0d", i), outs(), tbl[i].exp);
    end

    // reset in the middle of a service
    @(negedge clk);
    irq_in  = 2'b11;
    we_mask = 1'b0;
    iret    = 1'b0;
    n = 0;
    while (!intr1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rms_issue", {6'b0, intr1}, 7'b1);
    chk("rms_latency", 7'(n), 7'd4);
    chk("rms_issue_state", outs(), 7'b1_0_10_01_1);
    @(posedge clk); #1;
    chk("rms_service", outs(), 7'b0_0_10_01_1);
    #1 reset = 1'b0;
    #1 chk("rms_async_clear", outs(), 7'b0);
    @(negedge clk) irq_in = 2'b00;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) iret = 1'b1;
    @(posedge clk); #1;
    chk("rms_iret_ignored", outs(), 7'b0);
    @(negedge clk) iret = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rms_quiet", outs(), 7'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
